nonce_hub_fifo: RTL

Parametrised successor to the nonce hub: collects golden nonces from `SLAVES` hasher cores running on another clock and forwards them one at a time to the UART transmitter. Each slave has a `DEPTH`-entry queue, so bursts of back-to-back nonces are not lost. A fair round-robin arbiter drains the queues. Dropped nonces are counted rather than silently lost. Sits between the hasher array and the serial TX block in the uart clock domain.

---
 rtl/nonce_hub_fifo.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/nonce_hub_fifo.sv
// Collects golden nonces from SLAVES hasher cores through per-slave FIFOs and
// forwards them one at a time to the UART transmitter under round-robin arbitration.
module nonce_hub_fifo #(
  parameter int SLAVES      = 2,
  parameter int NONCE_WIDTH = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DROP_WIDTH  = 16,
  localparam int SW         = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
  input  logic                          uart_clk,
  input  logic                          rst_n,
  input  logic [SLAVES-1:0]             new_nonces,
  input  logic [SLAVES*NONCE_WIDTH-1:0] slave_nonces,
  input  logic                          serial_busy,
  output logic                          serial_send,
  output logic [NONCE_WIDTH-1:0]        golden_nonce,
  output logic [SW-1:0]                 golden_slave,
  output logic                          pending,
  output logic [DROP_WIDTH-1:0]         drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = DROP_WIDTH + $clog2(SLAVES + 1) + 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [SLAVES-1:0]      sync_p [SYNC_STAGES];
  logic [SLAVES-1:0]      dly_p;
  logic [SLAVES-1:0]      push, pop, full, empty;
  logic [AW:0]            wptr [SLAVES];
  logic [AW:0]            rptr [SLAVES];
  logic [NONCE_WIDTH-1:0] mem [SLAVES][DEPTH];
  logic [NONCE_WIDTH-1:0] head;
  logic [SW-1:0]          rr, rr_next, gnt_idx;
  logic                   found, gnt;
  logic [CW-1:0]          ndrop;
  int                     k;

  function automatic logic [DROP_WIDTH-1:0] sat_add(input logic [DROP_WIDTH-1:0] a,
                                                    input logic [CW-1:0] b);
    logic [CW-1:0] s;
    s = CW'(a) + b;
    if (|s[CW-1:DROP_WIDTH]) return '1;
    return s[DROP_WIDTH-1:0];
  endfunction

  // Stage: synchroniser chain plus edge-detect delay flop
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_p[s] <= '0;
      dly_p <= '0;
    end else begin
      sync_p[0] <= new_nonces;
      for (int s = 1; s < SYNC_STAGES; s++) sync_p[s] <= sync_p[s-1];
      dly_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign push = sync_p[SYNC_STAGES-1] & ~dly_p;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < SLAVES; i++) begin
      empty[i] = (wptr[i] == rptr[i]);
      full[i]  = (wptr[i][AW] != rptr[i][AW]) && (wptr[i][AW-1:0] == rptr[i][AW-1:0]);
    end
  end

  // Round-robin search starting at rr; the send term covers the TX busy lag.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    rr_next = rr;
    k       = 0;
    for (int j = 0; j < SLAVES; j++) begin
      k = int'(rr) + j;
      if (k >= SLAVES) k = k - SLAVES;
      if (!found && !empty[k]) begin
        found   = 1'b1;
        gnt_idx = SW'(k);
        rr_next = (k + 1 == SLAVES) ? '0 : SW'(k + 1);
      end
    end
    gnt = found && !serial_busy && !serial_send;
    pop = '0;
    if (gnt) pop[gnt_idx] = 1'b1;
  end

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < SLAVES; i++)
      if (push[i] && full[i] && !pop[i]) ndrop = ndrop + CW'(1);
  end

  assign head = mem[gnt_idx][rptr[gnt_idx][AW-1:0]];

  // Stage: FIFO pointers (a full FIFO still accepts a push when popped the same cycle)
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLAVES; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLAVES; i++) begin
        if (push[i] && (!full[i] || pop[i])) wptr[i] <= wptr[i] + PTR_ONE;
        if (pop[i]) rptr[i] <= rptr[i] + PTR_ONE;
      end
    end
  end

  always_ff @(posedge uart_clk) begin
    for (int i = 0; i < SLAVES; i++)
      if (push[i] && (!full[i] || pop[i]))
        mem[i][wptr[i][AW-1:0]] <= slave_nonces[i*NONCE_WIDTH +: NONCE_WIDTH];
  end

  // Stage: grant outputs, status and drop counter
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      serial_send  <= 1'b0;
      golden_nonce <= '0;
      golden_slave <= '0;
      pending      <= 1'b0;
      drop_count   <= '0;
      rr           <= '0;
    end else begin
      serial_send <= gnt;
      pending     <= |(~empty);
      drop_count  <= sat_add(drop_count, ndrop);
      if (gnt) begin
        golden_nonce <= head;
        golden_slave <= gnt_idx;
        rr           <= rr_next;
      end
    end
  end

endmodule
